prbs_stream: RTL and testbench

PRBS_STREAM -- requirements
Module: prbs_stream

---
 rtl/prbs_stream_pkg.sv | 32 +++
 rtl/prbs_stream_if.sv | 12 +
 rtl/prbs_stream_lane.sv | 42 ++++
 rtl/prbs_stream.sv | 137 +++++++++++++
 tb/tb_prbs_stream.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/prbs_stream_pkg.sv
// Shared definitions for the multi-lane PRBS31 / counter stream generator:
// FSM states, mode encodings, PRBS31 tap positions and the per-lane seed rule.
package prbs_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        MODE_PRBS     = 2'b00,
        MODE_CNT      = 2'b01,
        MODE_ZERO     = 2'b10,
        MODE_PRBS_ALT = 2'b11
    } mode_t;

    localparam int WORD_W      = 32;
    localparam int PRBS_LEN    = 31;
    // x^31 + x^28 + 1: feedback taps on the oldest bit and the bit three younger
    localparam int PRBS_TAP_HI = 30;
    localparam int PRBS_TAP_LO = 27;

    function automatic logic [PRBS_LEN-1:0] lane_seed(int unsigned base, int unsigned idx);
        logic [PRBS_LEN-1:0] s;
        s = PRBS_LEN'(base + idx);
        if (s == '0)
            s = PRBS_LEN'(1);
        return s;
    endfunction

endpackage

// File: rtl/prbs_stream_if.sv
// AXI4-Stream style output bus of the PRBS stream generator, LANES x 32 bits wide.
interface prbs_stream_if #(
    parameter int LANES = 16
);
    logic [32*LANES-1:0] tdata;
    logic                tvalid;
    logic                tready;
    logic                tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/prbs_stream_lane.sv
// One PRBS31 lane: presents the next 32 generated bits on word (first bit at
// bit 0) and jumps 32 bit-steps ahead when advance is asserted.
module prbs31_lane
    import prbs_stream_pkg::*;
#(
    parameter logic [PRBS_LEN-1:0] SEED = 31'd1
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              load,
    input  logic              advance,
    output logic [WORD_W-1:0] word
);

    logic [PRBS_LEN-1:0] state;
    logic [PRBS_LEN-1:0] state_nxt;
    logic [PRBS_LEN-1:0] s;
    logic                nb;

    // Unrolled 32-step jump; bit 0 of the shift register is the newest bit.
    always_comb begin
        s    = state;
        nb   = 1'b0;
        word = '0;
        for (int j = 0; j < WORD_W; j++) begin
            nb      = s[PRBS_TAP_HI] ^ s[PRBS_TAP_LO];
            word[j] = nb;
            s       = {s[PRBS_LEN-2:0], nb};
        end
        state_nxt = s;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            state <= SEED;
        else if (load)
            state <= SEED;
        else if (advance)
            state <= state_nxt;
    end

endmodule

// File: rtl/prbs_stream.sv
// Multi-lane test-pattern streamer: PRBS31, counter or all-zero beats on an
// AXI-Stream master, with run control and single-beat bit-0 error injection.
module prbs_stream
    import prbs_stream_pkg::*;
#(
    parameter int          LANES     = 16,
    parameter int unsigned SEED_BASE = 1
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    input  logic [31:0] beats,
    input  logic [1:0]  mode,
    input  logic        inject_err,
    output logic        busy,
    output logic        done,
    prbs_stream_if.master m_axis
);

    state_t      state;
    mode_t       mode_q;
    logic [31:0] beats_q;
    logic [31:0] cnt;
    logic [31:0] cnt_nxt;
    logic [31:0] cnt_base;
    logic        err_q;
    logic        tvalid_q;
    logic        tlast_q;
    logic        accept;
    logic        load;

    logic [WORD_W-1:0]       lane_word [LANES];
    logic [WORD_W*LANES-1:0] data;

    assign accept  = tvalid_q && m_axis.tready;
    assign load    = (state == ST_IDLE) && start;
    assign cnt_nxt = cnt + 32'd1;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        prbs31_lane #(
            .SEED (lane_seed(SEED_BASE, i))
        ) u_lane (
            .clock   (clock),
            .resetn  (resetn),
            .load    (load),
            .advance (accept),
            .word    (lane_word[i])
        );
    end

    // Error injection flips only the presented bit; lane and counter state stay clean.
    always_comb begin
        data     = '0;
        cnt_base = cnt * 32'(LANES);
        for (int i = 0; i < LANES; i++) begin
            case (mode_q)
                MODE_CNT:  data[i*WORD_W +: WORD_W] = cnt_base + 32'(i);
                MODE_ZERO: data[i*WORD_W +: WORD_W] = '0;
                default:   data[i*WORD_W +: WORD_W] = lane_word[i];
            endcase
        end
        if (err_q)
            data[0] = ~data[0];
    end

    assign m_axis.tdata  = tvalid_q ? data : '0;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tlast_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            mode_q   <= MODE_PRBS;
            beats_q  <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mode_q  <= mode_t'(mode);
                        beats_q <= beats;
                        cnt     <= '0;
                        if (beats == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= ST_RUN;
                            busy     <= 1'b1;
                            tvalid_q <= 1'b1;
                            tlast_q  <= (beats == 32'd1);
                        end
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        cnt <= cnt_nxt;
                        if (tlast_q) begin
                            state    <= ST_DONE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            tvalid_q <= 1'b0;
                            tlast_q  <= 1'b0;
                        end else begin
                            tlast_q <= (cnt_nxt == beats_q - 32'd1);
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state    <= ST_IDLE;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    tvalid_q <= 1'b0;
                    tlast_q  <= 1'b0;
                end
            endcase
        end
    end

    // A pending request absorbs further requests until its beat is accepted.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            err_q <= 1'b0;
        else if (accept && err_q)
            err_q <= 1'b0;
        else if (inject_err)
            err_q <= 1'b1;
    end

endmodule

// File: tb/tb_prbs_stream.sv
// Bench for prbs_stream: sequence-level PRBS31 / counter model checked every
// cycle, plus hand-computed literal words for the first beats.
module tb_prbs_stream;
    localparam int          NL = 16;
    localparam int          W  = 32 * NL;
    localparam int unsigned SB = 1;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        inject_err = 1'b0;
    logic [31:0] beats = '0;
    logic [1:0]  mode = 2'b00;
    logic        busy;
    logic        done;

    prbs_stream_if #(.LANES(NL)) axis ();

    prbs_stream #(.LANES(NL), .SEED_BASE(SB)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .start      (start),
        .beats      (beats),
        .mode       (mode),
        .inject_err (inject_err),
        .busy       (busy),
        .done       (done),
        .m_axis     (axis)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef enum int {M_IDLE, M_RUN, M_DONE} mph_t;
    mph_t        ph = M_IDLE;
    int unsigned m_beats = 0;
    int unsigned m_beat  = 0;
    logic [1:0]  m_mode  = 2'b00;
    bit          m_err   = 1'b0;
    bit          hist [NL][$];
    logic [31:0] cw [NL];
    bit          stalled = 1'b0;
    logic [W-1:0] prev_tdata = '0;

    function automatic logic [30:0] seed_of(int l);
        longint unsigned s;
        s = (longint'(SB) + longint'(l)) % 64'h8000_0000;
        if (s == 0) s = 1;
        return s[30:0];
    endfunction

    // Sequence b[n] = b[n-31] ^ b[n-28]; hist holds b[n-31]..b[n-1], oldest first.
    task automatic gen_word(int l);
        bit nb;
        for (int j = 0; j < 32; j++) begin
            nb = hist[l][0] ^ hist[l][3];
            hist[l].push_back(nb);
            void'(hist[l].pop_front());
            cw[l][j] = nb;
        end
    endtask

    task automatic model_load();
        logic [30:0] sd;
        for (int l = 0; l < NL; l++) begin
            sd = seed_of(l);
            hist[l].delete();
            for (int k = 0; k < 31; k++) hist[l].push_back(sd[30-k]);
            gen_word(l);
        end
    endtask

    function automatic logic [31:0] exp_word(int l);
        logic [31:0] w;
        case (m_mode)
            2'b01:   w = m_beat * NL + l;
            2'b10:   w = 32'd0;
            default: w = cw[l];
        endcase
        if (l == 0 && m_err) w[0] = ~w[0];
        return w;
    endfunction

    function automatic logic [W-1:0] exp_tdata();
        logic [W-1:0] e;
        for (int l = 0; l < NL; l++) e[l*32 +: 32] = exp_word(l);
        return e;
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        if (!resetn) begin
            chk("rst_busy",   busy, 0);
            chk("rst_done",   done, 0);
            chk("rst_tvalid", axis.tvalid, 0);
            chk("rst_tlast",  axis.tlast, 0);
            chk("rst_tdata",  axis.tdata, 0);
            ph = M_IDLE; m_err = 0; stalled = 0;
        end else begin
            chk("busy",   busy, ph == M_RUN);
            chk("done",   done, ph == M_DONE);
            chk("tvalid", axis.tvalid, ph == M_RUN);
            if (ph == M_RUN) begin
                chk("tdata", axis.tdata, exp_tdata());
                chk("tlast", axis.tlast, m_beat == m_beats - 1);
                if (stalled) chk("stall_hold", axis.tdata, prev_tdata);
            end else begin
                chk("tlast_idle", axis.tlast, 0);
            end
            stalled    = (ph == M_RUN) && !axis.tready;
            prev_tdata = axis.tdata;

            if (ph == M_RUN && axis.tready && m_err) m_err = 0;
            else if (inject_err) m_err = 1;

            case (ph)
                M_IDLE: if (start) begin
                    m_beats = beats; m_mode = mode; m_beat = 0;
                    model_load();
                    ph = (beats == 0) ? M_DONE : M_RUN;
                end
                M_RUN: if (axis.tready) begin
                    if (m_beat == m_beats - 1) ph = M_DONE;
                    else begin
                        m_beat++;
                        for (int l = 0; l < NL; l++) gen_word(l);
                    end
                end
                default: ph = M_IDLE;
            endcase
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_start(int unsigned b, logic [1:0] m);
        @(posedge clock); #1;
        start = 1; beats = b; mode = m;
        @(posedge clock); #1;
        start = 0;
    endtask

    task automatic wait_idle(int limit, bit rnd);
        int k = 0;
        while (ph != M_IDLE && k < limit) begin
            @(posedge clock); #1;
            if (rnd) axis.tready = 1'($urandom_range(0, 1));
            k++;
        end
        chk("run_finished", ph == M_IDLE, 1);
        axis.tready = 1;
    endtask

    initial begin
        axis.tready = 1;
        // Pin the model against hand-derived words (seed 1: bits 27,30 then 23,29).
        m_mode = 2'b00;
        model_load();
        chk("pin_lane0_w0", cw[0], 32'h4800_0000);
        chk("pin_lane1_w0", cw[1], 32'h2400_0000);
        gen_word(0);
        chk("pin_lane0_w1", cw[0], 32'h2080_0000);
        m_mode = 2'b01; m_beat = 3;
        chk("pin_cnt_b3_l5", exp_word(5), 32'd53);
        m_mode = 2'b00; m_beat = 0;

        repeat (3) @(posedge clock);
        #1 resetn = 1;

        // Two injects in idle collapse into one corrupted beat 0; counter mode.
        @(posedge clock); #1 inject_err = 1;
        @(posedge clock); #1 inject_err = 1;
        @(posedge clock); #1 inject_err = 0;
        do_start(4, 2'b01);
        @(negedge clock);
        chk("cnt_b0_l5", axis.tdata[5*32 +: 32], 32'd5);
        chk("cnt_b0_l0_err", axis.tdata[31:0], 32'd1);
        @(negedge clock);
        chk("cnt_b1_l0", axis.tdata[31:0], 32'd16);
        chk("cnt_b1_l5", axis.tdata[5*32 +: 32], 32'd21);
        wait_idle(20, 0);

        // Zero-beat run: straight to done, no tvalid, no busy.
        do_start(0, 2'b00);
        wait_idle(10, 0);

        // Long PRBS run with random backpressure.
        axis.tready = 0;
        do_start(1000, 2'b00);
        @(negedge clock);
        chk("prbs_b0_l0", axis.tdata[31:0], 32'h4800_0000);
        chk("prbs_b0_l1", axis.tdata[63:32], 32'h2400_0000);
        wait_idle(8000, 1);

        // Inject on beat 5 of a 10-beat run, mode 11 behaves as PRBS.
        do_start(10, 2'b11);
        repeat (4) @(posedge clock);
        #1 inject_err = 1;
        @(posedge clock); #1 inject_err = 0;
        wait_idle(40, 0);

        // Zero mode run.
        do_start(3, 2'b10);
        wait_idle(20, 0);

        // Start during RUN is ignored, then reset mid-run.
        do_start(20, 2'b00);
        repeat (3) @(posedge clock);
        #1 start = 1; beats = 2; mode = 2'b01;
        @(posedge clock); #1 start = 0;
        repeat (3) @(posedge clock);
        #1 resetn = 0;
        repeat (2) @(posedge clock);
        #1 resetn = 1;
        @(negedge clock);
        chk("post_rst_idle", ph == M_IDLE, 1);

        // Rerun restarts from seeds.
        do_start(5, 2'b00);
        @(negedge clock);
        chk("rerun_b0_l0", axis.tdata[31:0], 32'h4800_0000);
        wait_idle(30, 0);

        repeat (3) @(posedge clock);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
